// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32 decode, forwarding, load-use hazard detection and ID/EX pipeline register.
module id_ex_stage #(
   parameter int WORD_SIZE = 32,
   parameter int REG_ADDR  = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [31:0]          in_instr,
   input  logic [WORD_SIZE-1:0] in_pc,
   output logic [REG_ADDR-1:0]  rs1_addr,
   output logic [REG_ADDR-1:0]  rs2_addr,
   input  logic [WORD_SIZE-1:0] rf_rs1,
   input  logic [WORD_SIZE-1:0] rf_rs2,
   input  logic                 ex_mem_valid,
   input  logic                 ex_mem_is_load,
   input  logic [REG_ADDR-1:0]  ex_mem_rd,
   input  logic [WORD_SIZE-1:0] ex_mem_data,
   input  logic                 mem_wb_valid,
   input  logic [REG_ADDR-1:0]  mem_wb_rd,
   input  logic [WORD_SIZE-1:0] mem_wb_data,
   input  logic                 ex_stall,
   input  logic                 flush,
   output logic                 stall_out,
   output logic                 ex_valid,
   output logic [6:0]           ex_opcode,
   output logic [6:0]           ex_funct7,
   output logic [2:0]           ex_funct3,
   output logic [WORD_SIZE-1:0] ex_alu_in1,
   output logic [WORD_SIZE-1:0] ex_alu_in2,
   output logic [WORD_SIZE-1:0] ex_store_data,
   output logic [REG_ADDR-1:0]  ex_rd,
   output logic [WORD_SIZE-1:0] ex_pc,
   output logic [WORD_SIZE-1:0] ex_branch_target,
   output logic                 ex_illegal
);
   localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                          ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
   logic [6:0] opc;
   logic legal, use1, use2, lu1, lu2, hazard;
   logic [WORD_SIZE-1:0] imm_i, imm_s, imm_b, imm_j, src1, src2, in1, in2, sd, bt;
   logic [REG_ADDR-1:0] rd;
   assign opc = in_instr[6:0];
   assign rs1_addr = REG_ADDR'(in_instr[19:15]);
   assign rs2_addr = REG_ADDR'(in_instr[24:20]);
   assign imm_i = {{(WORD_SIZE-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{(WORD_SIZE-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{(WORD_SIZE-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_j = {{(WORD_SIZE-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   // A load still in EX/MEM has no data yet, so it is excluded from forwarding.
   assign src1 = rs1_addr == '0 ? '0
               : (ex_mem_valid && !ex_mem_is_load && ex_mem_rd == rs1_addr) ? ex_mem_data
               : (mem_wb_valid && mem_wb_rd == rs1_addr) ? mem_wb_data : rf_rs1;
   assign src2 = rs2_addr == '0 ? '0
               : (ex_mem_valid && !ex_mem_is_load && ex_mem_rd == rs2_addr) ? ex_mem_data
               : (mem_wb_valid && mem_wb_rd == rs2_addr) ? mem_wb_data : rf_rs2;
   assign use1 = opc != JAL;
   assign use2 = opc == OP || opc == ST || opc == BR;
   assign lu1 = rs1_addr != '0 && ((ex_valid && ex_opcode == LD && ex_rd == rs1_addr) ||
                                   (ex_mem_valid && ex_mem_is_load && ex_mem_rd == rs1_addr));
   assign lu2 = rs2_addr != '0 && ((ex_valid && ex_opcode == LD && ex_rd == rs2_addr) ||
                                   (ex_mem_valid && ex_mem_is_load && ex_mem_rd == rs2_addr));
   assign hazard = in_valid && ((use1 && lu1) || (use2 && lu2));
   assign stall_out = !rst && !flush && (hazard || ex_stall);
   always_comb begin
      legal = opc == OP || opc == OPI || opc == LD || opc == ST || opc == BR || opc == JAL;
      in1 = !legal ? '0 : opc == JAL ? in_pc + imm_j : src1;
      in2 = (!legal || opc == JAL) ? '0 : (opc == OPI || opc == LD) ? imm_i : opc == ST ? imm_s : src2;
      sd = opc == ST ? src2 : '0;
      bt = opc == BR ? in_pc + imm_b : '0;
      rd = (!legal || opc == ST || opc == BR) ? '0 : REG_ADDR'(in_instr[11:7]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_illegal <= 1'b0;
         ex_opcode <= '0;
         ex_funct7 <= '0;
         ex_funct3 <= '0;
         ex_alu_in1 <= '0;
         ex_alu_in2 <= '0;
         ex_store_data <= '0;
         ex_rd <= '0;
         ex_pc <= '0;
         ex_branch_target <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (!ex_stall) begin
         if (hazard) begin
            ex_valid <= 1'b0;
            ex_illegal <= 1'b0;
         end else begin
            ex_valid <= in_valid;
            ex_illegal <= in_valid && !legal;
            ex_opcode <= opc;
            ex_funct7 <= in_instr[31:25];
            ex_funct3 <= in_instr[14:12];
            ex_alu_in1 <= in1;
            ex_alu_in2 <= in2;
            ex_store_data <= sd;
            ex_rd <= rd;
            ex_pc <= in_pc;
            ex_branch_target <= bt;
         end
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for id_ex_stage.
module tb_id_ex_stage;
   logic clk = 1'b0, rst, in_valid, ex_mem_valid, ex_mem_is_load, mem_wb_valid, ex_stall, flush;
   logic [31:0] in_instr, in_pc, rf_rs1, rf_rs2, ex_mem_data, mem_wb_data;
   logic [4:0] rs1_addr, rs2_addr, ex_mem_rd, mem_wb_rd, ex_rd;
   logic stall_out, ex_valid, ex_illegal;
   logic [6:0] ex_opcode, ex_funct7;
   logic [2:0] ex_funct3;
   logic [31:0] ex_alu_in1, ex_alu_in2, ex_store_data, ex_pc, ex_branch_target;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .ex_mem_valid(ex_mem_valid), .ex_mem_is_load(ex_mem_is_load), .ex_mem_rd(ex_mem_rd),
      .ex_mem_data(ex_mem_data), .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
      .mem_wb_data(mem_wb_data), .ex_stall(ex_stall), .flush(flush), .stall_out(stall_out),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
      .ex_alu_in1(ex_alu_in1), .ex_alu_in2(ex_alu_in2), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_branch_target(ex_branch_target), .ex_illegal(ex_illegal)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1; in_valid = 1; in_instr = 32'h0000A283; in_pc = 32'hDEAD; rf_rs1 = 32'h55; rf_rs2 = 32'h66;
      ex_mem_valid = 1; ex_mem_is_load = 1; ex_mem_rd = 5'd1; ex_mem_data = 32'h77;
      mem_wb_valid = 1; mem_wb_rd = 5'd3; mem_wb_data = 32'h88; ex_stall = 1; flush = 0;
      #1;
      check("rst_stall_out", {31'd0, stall_out}, 0);
      step(); step();
      check("rst_valid", {31'd0, ex_valid}, 0);
      check("rst_illegal", {31'd0, ex_illegal}, 0);
      check("rst_opcode", {25'd0, ex_opcode}, 0);
      check("rst_in1", ex_alu_in1, 0);
      check("rst_in2", ex_alu_in2, 0);
      check("rst_rd", {27'd0, ex_rd}, 0);
      check("rst_pc", ex_pc, 0);
      check("rst_bt", ex_branch_target, 0);
      check("rst_sd", ex_store_data, 0);
      rst = 0; ex_stall = 0; ex_mem_valid = 0; ex_mem_is_load = 0; mem_wb_valid = 0;
      // add x3,x1,x2
      in_instr = 32'h002081B3; in_pc = 32'h100; rf_rs1 = 5; rf_rs2 = 7;
      #1;
      check("rs1_addr", {27'd0, rs1_addr}, 1);
      check("rs2_addr", {27'd0, rs2_addr}, 2);
      check("add_stall", {31'd0, stall_out}, 0);
      step();
      check("add_valid", {31'd0, ex_valid}, 1);
      check("add_opcode", {25'd0, ex_opcode}, 32'h33);
      check("add_in1", ex_alu_in1, 5);
      check("add_in2", ex_alu_in2, 7);
      check("add_rd", {27'd0, ex_rd}, 3);
      check("add_pc", ex_pc, 32'h100);
      // addi x1,x0,-4
      in_instr = 32'hFFC00093; rf_rs1 = 32'h1234;
      step();
      check("addi_in1", ex_alu_in1, 0);
      check("addi_in2", ex_alu_in2, 32'hFFFFFFFC);
      check("addi_rd", {27'd0, ex_rd}, 1);
      check("addi_opcode", {25'd0, ex_opcode}, 32'h13);
      // lw x5,0(x1) then add x6,x5,x5
      in_instr = 32'h0000A283; rf_rs1 = 32'h40;
      step();
      check("lw_in1", ex_alu_in1, 32'h40);
      check("lw_rd", {27'd0, ex_rd}, 5);
      check("lw_opcode", {25'd0, ex_opcode}, 32'h03);
      in_instr = 32'h00528333; rf_rs1 = 0; rf_rs2 = 0;
      #1;
      check("lu_stall1", {31'd0, stall_out}, 1);
      step();
      check("lu_bubble1", {31'd0, ex_valid}, 0);
      ex_mem_valid = 1; ex_mem_is_load = 1; ex_mem_rd = 5'd5; ex_mem_data = 32'hBAD;
      #1;
      check("lu_stall2", {31'd0, stall_out}, 1);
      step();
      check("lu_bubble2", {31'd0, ex_valid}, 0);
      ex_mem_valid = 0; ex_mem_is_load = 0; mem_wb_valid = 1; mem_wb_rd = 5'd5; mem_wb_data = 32'hCAFE;
      #1;
      check("lu_release", {31'd0, stall_out}, 0);
      step();
      check("lu_valid", {31'd0, ex_valid}, 1);
      check("lu_in1", ex_alu_in1, 32'hCAFE);
      check("lu_in2", ex_alu_in2, 32'hCAFE);
      check("lu_rd", {27'd0, ex_rd}, 6);
      // forwarding priority on rs2 = x2
      in_instr = 32'h002081B3; rf_rs1 = 9; rf_rs2 = 32'h33;
      ex_mem_valid = 1; ex_mem_rd = 5'd2; ex_mem_data = 32'h11;
      mem_wb_valid = 1; mem_wb_rd = 5'd2; mem_wb_data = 32'h22;
      step();
      check("fwd_exmem", ex_alu_in2, 32'h11);
      check("fwd_in1_rf", ex_alu_in1, 9);
      ex_mem_valid = 0;
      step();
      check("fwd_memwb", ex_alu_in2, 32'h22);
      mem_wb_valid = 0;
      step();
      check("fwd_rf", ex_alu_in2, 32'h33);
      // sw x2,8(x1)
      in_instr = 32'h0020A423;
      step();
      check("sw_in1", ex_alu_in1, 9);
      check("sw_in2", ex_alu_in2, 8);
      check("sw_data", ex_store_data, 32'h33);
      check("sw_rd", {27'd0, ex_rd}, 0);
      // beq x1,x2,-8 at pc 0x200
      in_instr = 32'hFE208CE3; in_pc = 32'h200;
      step();
      check("beq_target", ex_branch_target, 32'h1F8);
      check("beq_in2", ex_alu_in2, 32'h33);
      check("beq_rd", {27'd0, ex_rd}, 0);
      // jal x1,+16 at pc 0x300
      in_instr = 32'h010000EF; in_pc = 32'h300;
      step();
      check("jal_in1", ex_alu_in1, 32'h310);
      check("jal_in2", ex_alu_in2, 0);
      check("jal_rd", {27'd0, ex_rd}, 1);
      // flush with stall
      in_instr = 32'h002081B3; flush = 1; ex_stall = 1;
      #1;
      check("flush_stall_out", {31'd0, stall_out}, 0);
      step();
      check("flush_valid", {31'd0, ex_valid}, 0);
      flush = 0; ex_stall = 0; in_instr = 32'h0000007F;
      step();
      check("ill_illegal", {31'd0, ex_illegal}, 1);
      check("ill_valid", {31'd0, ex_valid}, 1);
      check("ill_in1", ex_alu_in1, 0);
      check("ill_rd", {27'd0, ex_rd}, 0);
      // downstream hold keeps the illegal instruction in place
      in_instr = 32'h002081B3; ex_stall = 1;
      #1;
      check("hold_stall_out", {31'd0, stall_out}, 1);
      step();
      check("hold_illegal", {31'd0, ex_illegal}, 1);
      check("hold_opcode", {25'd0, ex_opcode}, 32'h7F);
      ex_stall = 0;
      step();
      check("resume_illegal", {31'd0, ex_illegal}, 0);
      check("resume_in1", ex_alu_in1, 9);
      in_valid = 0;
      step();
      check("idle_valid", {31'd0, ex_valid}, 0);
      // flush during a hazard still inserts a bubble, without stalling
      in_valid = 1; in_instr = 32'h0000A283;
      step();
      in_instr = 32'h00528333; flush = 1;
      #1;
      check("flush_hz_stall", {31'd0, stall_out}, 0);
      flush = 0;
      #1;
      check("hz_stall", {31'd0, stall_out}, 1);
      rst = 1;
      #1;
      check("rst_hz_stall", {31'd0, stall_out}, 0);
      step();
      check("rst_hz_valid", {31'd0, ex_valid}, 0);
      check("rst_hz_rd", {27'd0, ex_rd}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
